vdcram_arbiter: RTL and testbench

- Arbitrates the single-port VDC video RAM between three users: display fetch, CPU data-register access, and an internal block copy/fill engine.
- The arbiter is the only driver of the RAM address, write-enable and write-data inputs.
- The RAM captures the address synchronously and presents read data in the cycle after capture.
- The arbiter sits between the VDC register file / display timing logic and the RAM instance.

---
 rtl/vdcram_arbiter_pkg.sv | 22 ++
 rtl/vdcram_arbiter_if.sv | 56 +++++
 rtl/vdcram_arbiter_blkengine.sv | 100 ++++++++++
 rtl/vdcram_arbiter.sv | 116 +++++++++++
 tb/tb_vdcram_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdcram_arbiter_pkg.sv
// rtl/vdcram_arbiter_pkg.sv - shared types for the VDC RAM arbiter
package vdcram_arbiter_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_CPU,
        GNT_BLK
    } gnt_t;

    typedef enum logic [2:0] {
        BLK_IDLE,
        BLK_COPY_RD,
        BLK_COPY_WAIT,
        BLK_COPY_WR,
        BLK_FILL_WR,
        BLK_DONE
    } blk_state_t;

endpackage

// File: rtl/vdcram_arbiter_if.sv
// rtl/vdcram_arbiter_if.sv - user and RAM signal bundle around the VDC RAM arbiter
interface vdcram_arbiter_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
);
    logic                                disp_req;
    logic [ADDRESS_WIDTH-1:0]            disp_addr;
    logic [DATA_WIDTH-1:0]               disp_data;
    logic                                disp_valid;

    logic                                cpu_req;
    logic                                cpu_we;
    logic [ADDRESS_WIDTH-1:0]            cpu_addr;
    logic [DATA_WIDTH-1:0]               cpu_wdata;
    logic                                cpu_ack;
    logic [DATA_WIDTH-1:0]               cpu_rdata;

    logic                                blk_start;
    logic                                blk_copy;
    logic [ADDRESS_WIDTH-1:0]            blk_src;
    logic [ADDRESS_WIDTH-1:0]            blk_dst;
    logic [vdcram_arbiter_pkg::CNT_W-1:0] blk_count;
    logic [DATA_WIDTH-1:0]               blk_fill;
    logic                                blk_busy;
    logic                                blk_done;
    logic [ADDRESS_WIDTH-1:0]            blk_src_end;
    logic [ADDRESS_WIDTH-1:0]            blk_dst_end;

    logic [ADDRESS_WIDTH-1:0]            ram_addr;
    logic                                ram_we;
    logic [DATA_WIDTH-1:0]               ram_dai;
    logic [DATA_WIDTH-1:0]               ram_dao;

    modport slave (
        input  disp_req, disp_addr,
        output disp_data, disp_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  blk_start, blk_copy, blk_src, blk_dst, blk_count, blk_fill,
        output blk_busy, blk_done, blk_src_end, blk_dst_end,
        output ram_addr, ram_we, ram_dai,
        input  ram_dao
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_data, disp_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output blk_start, blk_copy, blk_src, blk_dst, blk_count, blk_fill,
        input  blk_busy, blk_done, blk_src_end, blk_dst_end,
        input  ram_addr, ram_we, ram_dai,
        output ram_dao
    );

endinterface

// File: rtl/vdcram_arbiter_blkengine.sv
// rtl/vdcram_arbiter_blkengine.sv - block copy/fill engine issuing one RAM slot request at a time
module vdc_blkengine
    import vdcram_arbiter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             copy,
    input  logic [AW-1:0]    src_in,
    input  logic [AW-1:0]    dst_in,
    input  logic [CNT_W-1:0] count_in,
    input  logic [DW-1:0]    fill_in,
    output logic             req,
    output logic             we,
    output logic [AW-1:0]    addr,
    output logic [DW-1:0]    wdata,
    input  logic             gnt,
    input  logic             rvalid,
    input  logic [DW-1:0]    rdata,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    src_end,
    output logic [AW-1:0]    dst_end
);

    localparam int REM_W = CNT_W + 1;

    blk_state_t       state, state_nxt;
    logic [AW-1:0]    src, dst;
    logic [REM_W-1:0] remain;
    logic [DW-1:0]    hold, fill;

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        we        = 1'b0;
        addr      = dst;
        wdata     = hold;
        case (state)
            BLK_IDLE:      if (start) state_nxt = copy ? BLK_COPY_RD : BLK_FILL_WR;
            BLK_COPY_RD: begin
                req  = 1'b1;
                addr = src;
                if (gnt) state_nxt = BLK_COPY_WAIT;
            end
            BLK_COPY_WAIT: if (rvalid) state_nxt = BLK_COPY_WR;
            BLK_COPY_WR: begin
                req = 1'b1;
                we  = 1'b1;
                if (gnt) state_nxt = (remain == REM_W'(1)) ? BLK_DONE : BLK_COPY_RD;
            end
            BLK_FILL_WR: begin
                req   = 1'b1;
                we    = 1'b1;
                wdata = fill;
                if (gnt && remain == REM_W'(1)) state_nxt = BLK_DONE;
            end
            BLK_DONE:      state_nxt = BLK_IDLE;
            default:       state_nxt = BLK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= BLK_IDLE;
            src    <= '0;
            dst    <= '0;
            remain <= '0;
            hold   <= '0;
            fill   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                BLK_IDLE: if (start) begin
                    src    <= src_in;
                    dst    <= dst_in;
                    // a zero count encodes a full 256-byte block
                    remain <= (count_in == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count_in};
                    fill   <= fill_in;
                end
                BLK_COPY_RD:   if (gnt) src <= src + 1'b1;
                BLK_COPY_WAIT: if (rvalid) hold <= rdata;
                BLK_COPY_WR, BLK_FILL_WR: if (gnt) begin
                    dst    <= dst + 1'b1;
                    remain <= remain - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != BLK_IDLE) && (state != BLK_DONE);
    assign done    = (state == BLK_DONE);
    assign src_end = src;
    assign dst_end = dst;

endmodule

// File: rtl/vdcram_arbiter.sv
// rtl/vdcram_arbiter.sv - fixed-priority slot arbiter for the single-port VDC video RAM
module vdcram_arbiter
    import vdcram_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input logic                clk,
    input logic                reset_n,
    vdcram_arbiter_if.slave    bus
);

    gnt_t                     gnt, s1_gnt, s2_gnt;
    logic                     s1_we, s2_we;
    logic                     cpu_busy;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q;
    logic                     ram_we_q;
    logic [DATA_WIDTH-1:0]    ram_dai_q;
    logic [DATA_WIDTH-1:0]    disp_data_q, cpu_rdata_q;
    logic                     disp_valid_q, cpu_ack_q;

    logic                     eng_req, eng_we, eng_gnt, eng_rvalid;
    logic [ADDRESS_WIDTH-1:0] eng_addr;
    logic [DATA_WIDTH-1:0]    eng_wdata;

    // cpu_busy blocks re-grant until the ack cycle has passed, so a request
    // still held while the requester samples cpu_ack is not counted twice
    always_comb begin
        gnt = GNT_NONE;
        if (bus.disp_req)                  gnt = GNT_DISP;
        else if (bus.cpu_req && !cpu_busy) gnt = GNT_CPU;
        else if (eng_req)                  gnt = GNT_BLK;
    end

    assign eng_gnt    = (gnt == GNT_BLK);
    assign eng_rvalid = (s2_gnt == GNT_BLK) && !s2_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_gnt       <= GNT_NONE;
            s2_gnt       <= GNT_NONE;
            s1_we        <= 1'b0;
            s2_we        <= 1'b0;
            cpu_busy     <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_dai_q    <= '0;
            disp_data_q  <= '0;
            cpu_rdata_q  <= '0;
            disp_valid_q <= 1'b0;
            cpu_ack_q    <= 1'b0;
        end else begin
            ram_we_q     <= 1'b0;
            s1_gnt       <= gnt;
            s1_we        <= 1'b0;
            s2_gnt       <= s1_gnt;
            s2_we        <= s1_we;
            disp_valid_q <= (s2_gnt == GNT_DISP);
            cpu_ack_q    <= (s2_gnt == GNT_CPU);
            if (s2_gnt == GNT_DISP)           disp_data_q <= bus.ram_dao;
            if (s2_gnt == GNT_CPU && !s2_we)  cpu_rdata_q <= bus.ram_dao;
            if (gnt == GNT_CPU)               cpu_busy <= 1'b1;
            else if (cpu_ack_q)               cpu_busy <= 1'b0;
            case (gnt)
                GNT_DISP: ram_addr_q <= bus.disp_addr;
                GNT_CPU: begin
                    ram_addr_q <= bus.cpu_addr;
                    ram_we_q   <= bus.cpu_we;
                    ram_dai_q  <= bus.cpu_wdata;
                    s1_we      <= bus.cpu_we;
                end
                GNT_BLK: begin
                    ram_addr_q <= eng_addr;
                    ram_we_q   <= eng_we;
                    ram_dai_q  <= eng_wdata;
                    s1_we      <= eng_we;
                end
                default: ;
            endcase
        end
    end

    vdc_blkengine #(
        .AW (ADDRESS_WIDTH),
        .DW (DATA_WIDTH)
    ) u_blkengine (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (bus.blk_start),
        .copy     (bus.blk_copy),
        .src_in   (bus.blk_src),
        .dst_in   (bus.blk_dst),
        .count_in (bus.blk_count),
        .fill_in  (bus.blk_fill),
        .req      (eng_req),
        .we       (eng_we),
        .addr     (eng_addr),
        .wdata    (eng_wdata),
        .gnt      (eng_gnt),
        .rvalid   (eng_rvalid),
        .rdata    (bus.ram_dao),
        .busy     (bus.blk_busy),
        .done     (bus.blk_done),
        .src_end  (bus.blk_src_end),
        .dst_end  (bus.blk_dst_end)
    );

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_dai    = ram_dai_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vdcram_arbiter.sv
// tb/tb_vdcram_arbiter.sv - scoreboard bench for vdcram_arbiter with a behavioural synchronous RAM
module tb_vdcram_arbiter;

    typedef struct {
        logic [7:0] data;
        bit         we;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   done_cnt = 0;
    exp_t dq[$];
    exp_t cq[$];
    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vdcram_arbiter_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) bus();

    vdcram_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
    endfunction

    // synchronous RAM: address captured at the edge, data out after it
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(i);
        mem[16'h1234] = 8'h5A;
        bus.ram_dao = 8'h00;
        forever begin
            @(posedge clk);
            bus.ram_dao <= mem[bus.ram_addr];
            if (bus.ram_we) mem[bus.ram_addr] = bus.ram_dai;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.ram_we) we_cnt++;
        if (bus.blk_done) done_cnt++;
        if (bus.disp_valid) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL disp_unexpected: got disp_valid with data %0h, required no pulse", bus.disp_data);
            end else begin
                e = dq.pop_front();
                chk("disp_data", bus.disp_data, e.data);
                chk("disp_cycle", cyc, e.cyc);
            end
        end
        if (bus.cpu_ack) begin
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_unexpected: got cpu_ack, required no pulse");
            end else begin
                e = cq.pop_front();
                if (!e.we) chk("cpu_rdata", bus.cpu_rdata, e.data);
                if (e.cyc >= 0) chk("cpu_ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic disp_fetch(input logic [15:0] a);
        exp_t e;
        e.data = shadow[a];
        e.we   = 1'b0;
        e.cyc  = cyc + 3;
        dq.push_back(e);
        bus.disp_req  = 1'b1;
        bus.disp_addr = a;
        tick();
        bus.disp_req  = 1'b0;
    endtask

    task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d, input int lat);
        exp_t e;
        int   n;
        e.data = we ? 8'h00 : shadow[a];
        e.we   = we;
        e.cyc  = (lat >= 0) ? cyc + lat : -1;
        cq.push_back(e);
        if (we) shadow[a] = d;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cpu_ack && n < 200);
        if (!bus.cpu_ack) begin
            checks++; errors++;
            $display("FAIL cpu_ack_timeout: got no ack in %0d cycles, required ack", n);
        end
        tick();
        bus.cpu_req = 1'b0;
    endtask

    task automatic blk_op(input bit cp, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] cnt, input logic [7:0] fill,
                          input logic [15:0] s_end, input logic [15:0] d_end);
        logic [7:0] expv [256];
        int len, n, busy_err, done0, bad;
        bit seen;
        len = (cnt == 8'd0) ? 256 : int'(cnt);
        for (int i = 0; i < len; i++) expv[i] = cp ? shadow[16'(s + i)] : fill;
        done0 = done_cnt;
        busy_err = 0;
        bus.blk_copy  = cp;
        bus.blk_src   = s;
        bus.blk_dst   = d;
        bus.blk_count = cnt;
        bus.blk_fill  = fill;
        bus.blk_start = 1'b1;
        tick();
        bus.blk_start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 5000) begin
            @(negedge clk);
            n++;
            if (bus.blk_done) seen = 1'b1;
            else if (!bus.blk_busy) busy_err++;
        end
        chk("blk_done_seen", 32'(seen), 1);
        tick();
        tick();
        chk("blk_done_pulses", done_cnt - done0, 1);
        chk("blk_busy_held", busy_err, 0);
        chk("blk_busy_after", 32'(bus.blk_busy), 0);
        chk("blk_src_end", bus.blk_src_end, s_end);
        chk("blk_dst_end", bus.blk_dst_end, d_end);
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (mem[16'(d + i)] !== expv[i]) begin
                if (bad == 0) $display("FAIL blk_data at %0h: got %0h required %0h", 16'(d + i), mem[16'(d + i)], expv[i]);
                bad++;
            end
            shadow[16'(d + i)] = expv[i];
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, done0;
        bus.disp_req = 1'b0; bus.disp_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.blk_start = 1'b0; bus.blk_copy = 1'b0; bus.blk_src = '0; bus.blk_dst = '0;
        bus.blk_count = '0; bus.blk_fill = '0;
        for (int i = 0; i < 65536; i++) shadow[i] = pat(i);
        shadow[16'h1234] = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(|{bus.disp_data, bus.disp_valid, bus.cpu_ack, bus.cpu_rdata,
                                   bus.blk_busy, bus.blk_done, bus.blk_src_end, bus.blk_dst_end,
                                   bus.ram_addr, bus.ram_we, bus.ram_dai}), 0);
        reset_n = 1'b1;
        tick();

        // idle CPU read: ack three cycles after the request
        we0 = we_cnt;
        cpu_access(1'b0, 16'h1234, 8'h00, 3);
        tick();
        chk("idle_read_no_write", we_cnt - we0, 0);

        // display and CPU write on the same edge: display first, CPU one slot later
        fork
            disp_fetch(16'h0020);
            cpu_access(1'b1, 16'h0010, 8'h77, 4);
        join
        cpu_access(1'b0, 16'h0010, 8'h00, 3);
        chk("write_in_ram", mem[16'h0010], 8'h77);

        // fill across the top of the address space
        blk_op(1'b0, 16'h0000, 16'hFFFE, 8'd4, 8'hAA, 16'h0000, 16'h0002);
        chk("fill_wrap_ffff", mem[16'hFFFF], 8'hAA);
        chk("fill_wrap_0001", mem[16'h0001], 8'hAA);

        // 256-byte copy without contention
        blk_op(1'b1, 16'h1000, 16'h2000, 8'd0, 8'h00, 16'h1100, 16'h2100);

        // copy under display load plus a CPU read
        fork
            blk_op(1'b1, 16'h3000, 16'h3100, 8'd16, 8'h00, 16'h3010, 16'h3110);
            for (int k = 0; k < 20; k++) begin
                disp_fetch(16'(16'h5000 + k));
                tick();
            end
            begin
                repeat (9) tick();
                cpu_access(1'b0, 16'h6000, 8'h00, -1);
            end
        join
        repeat (4) tick();

        // reset in the middle of a long fill
        bus.blk_copy  = 1'b0;
        bus.blk_src   = 16'h0000;
        bus.blk_dst   = 16'h7000;
        bus.blk_count = 8'd200;
        bus.blk_fill  = 8'h55;
        bus.blk_start = 1'b1;
        tick();
        bus.blk_start = 1'b0;
        repeat (20) tick();
        done0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("midreset_ram_addr", bus.ram_addr, 0);
        chk("midreset_ram_we", 32'(bus.ram_we), 0);
        chk("midreset_blk_busy", 32'(bus.blk_busy), 0);
        chk("midreset_outputs", 32'(|{bus.disp_data, bus.disp_valid, bus.cpu_ack, bus.cpu_rdata,
                                      bus.blk_done, bus.blk_src_end, bus.blk_dst_end, bus.ram_dai}), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("midreset_no_done", done_cnt - done0, 0);
        blk_op(1'b0, 16'h0000, 16'h7100, 8'd3, 8'h66, 16'h0000, 16'h7103);

        repeat (5) tick();
        chk("disp_queue_empty", dq.size(), 0);
        chk("cpu_queue_empty", cq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
